// File: rtl/johnson_seq_monitor.sv
// Decodes samples from a 4-bit Johnson counter, tracks lock on the legal code sequence,
// flags out-of-sequence codes, and counts completed revolutions and errors.
module johnson_seq_monitor (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       En,
    input  logic [3:0] Q,
    output logic [2:0] Idx,
    output logic [7:0] OneHot,
    output logic       Valid,
    output logic       Illegal,
    output logic       SeqErr,
    output logic       Locked,
    output logic [7:0] Rev,
    output logic [3:0] ErrCnt
);
    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_LOCKED} state_t;

    state_t     r_state;
    logic [3:0] r_prev;
    logic [1:0] r_good;
    logic [2:0] r_idx;
    logic [7:0] r_onehot;
    logic       r_valid;
    logic       r_illegal;
    logic       r_seq_err;
    logic       r_locked;
    logic [7:0] r_rev;
    logic [3:0] r_err_cnt;

    logic       w_legal;
    logic [2:0] w_idx;
    logic [3:0] w_succ;
    logic       w_is_succ;
    logic       w_is_stall;

    always_comb begin
        w_legal = 1'b1;
        w_idx   = 3'd0;
        case (Q)
            4'b0000: w_idx = 3'd0;
            4'b1000: w_idx = 3'd1;
            4'b1100: w_idx = 3'd2;
            4'b1110: w_idx = 3'd3;
            4'b1111: w_idx = 3'd4;
            4'b0111: w_idx = 3'd5;
            4'b0011: w_idx = 3'd6;
            4'b0001: w_idx = 3'd7;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_succ     = {~r_prev[0], r_prev[3:1]};
    assign w_is_succ  = (Q == w_succ);
    assign w_is_stall = (Q == r_prev);

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state   <= ST_IDLE;
            r_prev    <= 4'b0000;
            r_good    <= 2'd0;
            r_idx     <= 3'd0;
            r_onehot  <= 8'd0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_seq_err <= 1'b0;
            r_locked  <= 1'b0;
            r_rev     <= 8'd0;
            r_err_cnt <= 4'd0;
        end else begin
            r_seq_err <= 1'b0;
            if (En) begin
                r_prev    <= Q;
                r_valid   <= w_legal;
                r_illegal <= ~w_legal;
                r_idx     <= w_legal ? w_idx : 3'd0;
                r_onehot  <= w_legal ? (8'd1 << w_idx) : 8'd0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_legal) begin
                            r_state <= ST_TRACK;
                            r_good  <= 2'd0;
                        end
                    end
                    ST_TRACK: begin
                        if (!w_legal) begin
                            r_state <= ST_IDLE;
                            r_good  <= 2'd0;
                        end else if (w_is_succ) begin
                            if (r_good == 2'd1) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                                r_good   <= 2'd0;
                            end else begin
                                r_good <= r_good + 2'd1;
                            end
                        end else if (!w_is_stall) begin
                            r_good <= 2'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_is_succ || w_is_stall) begin
                            // 0001 -> 0000 closes one full turn of the counter
                            if (w_is_succ && r_prev == 4'b0001)
                                r_rev <= r_rev + 8'd1;
                        end else begin
                            r_seq_err <= 1'b1;
                            r_locked  <= 1'b0;
                            r_good    <= 2'd0;
                            r_state   <= w_legal ? ST_TRACK : ST_IDLE;
                            if (r_err_cnt != 4'd15)
                                r_err_cnt <= r_err_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_locked <= 1'b0;
                        r_good   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign Idx     = r_idx;
    assign OneHot  = r_onehot;
    assign Valid   = r_valid;
    assign Illegal = r_illegal;
    assign SeqErr  = r_seq_err;
    assign Locked  = r_locked;
    assign Rev     = r_rev;
    assign ErrCnt  = r_err_cnt;
endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Bench for johnson_seq_monitor: index-based reference model checked every cycle,
// plus directed samples with hand-computed literal expectations.
module tb_johnson_seq_monitor;
    logic       Clk = 1'b0;
    logic       Clr;
    logic       En;
    logic [3:0] Q;
    logic [2:0] Idx;
    logic [7:0] OneHot;
    logic       Valid, Illegal, SeqErr, Locked;
    logic [7:0] Rev;
    logic [3:0] ErrCnt;

    int vectors = 0;
    int miscompares = 0;

    johnson_seq_monitor dut (
        .Clk(Clk), .Clr(Clr), .En(En), .Q(Q),
        .Idx(Idx), .OneHot(OneHot), .Valid(Valid), .Illegal(Illegal),
        .SeqErr(SeqErr), .Locked(Locked), .Rev(Rev), .ErrCnt(ErrCnt)
    );

    always #5 Clk = ~Clk;

    // Reference model: codes are handled as positions on the 8-step ring.
    logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};
    int  m_pos = 0;
    int  m_shown = 0;
    bit  m_valid = 0, m_seq = 0, m_locked = 0, m_tracking = 0, m_armed = 0;
    int  m_streak = 0, m_rev = 0, m_err = 0;

    function automatic int pos_of(input logic [3:0] c);
        for (int i = 0; i < 8; i++)
            if (codes[i] == c) return i;
        return -1;
    endfunction

    always @(posedge Clk) begin
        if (Clr) begin
            m_armed = 1; m_pos = 0; m_shown = 0; m_valid = 0; m_seq = 0;
            m_locked = 0; m_tracking = 0; m_streak = 0; m_rev = 0; m_err = 0;
        end else if (m_armed) begin
            m_seq = 0;
            if (En) begin
                int p;
                p = pos_of(Q);
                if (m_locked) begin
                    if (p >= 0 && (p == m_pos || p == (m_pos + 1) % 8)) begin
                        if (m_pos == 7 && p == 0) m_rev = (m_rev + 1) % 256;
                    end else begin
                        m_seq = 1;
                        if (m_err < 15) m_err++;
                        m_locked = 0;
                        m_tracking = (p >= 0);
                        m_streak = 0;
                    end
                end else if (m_tracking) begin
                    if (p < 0) m_tracking = 0;
                    else if (p == (m_pos + 1) % 8) begin
                        m_streak++;
                        if (m_streak == 2) begin
                            m_locked = 1; m_tracking = 0; m_streak = 0;
                        end
                    end else if (p != m_pos) m_streak = 0;
                end else if (p >= 0) begin
                    m_tracking = 1; m_streak = 0;
                end
                m_pos = p;
                m_valid = (p >= 0);
                m_shown = (p >= 0) ? p : 0;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (m_armed) begin
            cmp("model.Idx", int'(Idx), m_shown);
            cmp("model.OneHot", int'(OneHot), m_valid ? (1 << m_shown) : 0);
            cmp("model.Valid", int'(Valid), int'(m_valid));
            cmp("model.Illegal", int'(Illegal), (m_armed && !m_valid && m_pos < 0) ? 1 : 0);
            cmp("model.SeqErr", int'(SeqErr), int'(m_seq));
            cmp("model.Locked", int'(Locked), int'(m_locked));
            cmp("model.Rev", int'(Rev), m_rev);
            cmp("model.ErrCnt", int'(ErrCnt), m_err);
        end
    end

    task automatic smp(input logic clr, input logic en, input logic [3:0] q);
        Clr = clr; En = en; Q = q;
        @(posedge Clk);
        #1;
    endtask

    task automatic lock_from_idle();
        smp(0, 1, 4'b0000); smp(0, 1, 4'b1000); smp(0, 1, 4'b1100);
    endtask

    initial begin
        logic [3:0] seq9 [9] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        Clr = 1; En = 0; Q = 4'b0000;
        smp(1, 0, 4'b0000);
        smp(1, 0, 4'b0000);
        cmp("reset.Rev", int'(Rev), 0);
        cmp("reset.Locked", int'(Locked), 0);
        cmp("reset.Valid", int'(Valid), 0);

        // one full turn: indices 0..7 then 0, lock after third sample
        for (int i = 0; i < 9; i++) begin
            smp(0, 1, seq9[i]);
            cmp("turn.Idx", int'(Idx), i % 8);
            if (i == 1) cmp("turn.Locked2", int'(Locked), 0);
            if (i == 2) cmp("turn.Locked3", int'(Locked), 1);
        end
        cmp("turn.Rev", int'(Rev), 1);
        cmp("turn.SeqErr", int'(SeqErr), 0);

        // locked at 1100, illegal 0101
        smp(0, 1, 4'b1000); smp(0, 1, 4'b1100);
        smp(0, 1, 4'b0101);
        cmp("ill.Illegal", int'(Illegal), 1);
        cmp("ill.Valid", int'(Valid), 0);
        cmp("ill.OneHot", int'(OneHot), 0);
        cmp("ill.SeqErr", int'(SeqErr), 1);
        cmp("ill.ErrCnt", int'(ErrCnt), 1);
        cmp("ill.Locked", int'(Locked), 0);
        smp(0, 0, 4'b0000);
        cmp("ill.SeqErrPulse", int'(SeqErr), 0);

        // locked at 1100, skip to 1111, relock via 0111, 0011
        lock_from_idle();
        smp(0, 1, 4'b1111);
        cmp("skip.SeqErr", int'(SeqErr), 1);
        cmp("skip.Idx", int'(Idx), 4);
        cmp("skip.Locked", int'(Locked), 0);
        smp(0, 1, 4'b0111);
        cmp("skip.Track", int'(Locked), 0);
        smp(0, 1, 4'b0011);
        cmp("skip.Relock", int'(Locked), 1);

        // stalls while locked and with En low
        smp(0, 1, 4'b0001); smp(0, 1, 4'b0000);
        cmp("stall.Rev", int'(Rev), 2);
        smp(0, 1, 4'b1000); smp(0, 1, 4'b1100); smp(0, 1, 4'b1110);
        for (int i = 0; i < 3; i++) smp(0, 1, 4'b1110);
        for (int i = 0; i < 5; i++) begin
            smp(0, 0, 4'b0101);
            cmp("stall.SeqErr", int'(SeqErr), 0);
            cmp("stall.Idx", int'(Idx), 3);
        end
        cmp("stall.ErrCnt", int'(ErrCnt), 2);

        // revolution counter wrap
        smp(0, 1, 4'b1111); smp(0, 1, 4'b0111); smp(0, 1, 4'b0011);
        smp(0, 1, 4'b0001); smp(0, 1, 4'b0000);
        cmp("wrap.Rev3", int'(Rev), 3);
        for (int r = 0; r < 252; r++)
            for (int i = 1; i < 9; i++) smp(0, 1, seq9[i]);
        cmp("wrap.Rev255", int'(Rev), 255);
        for (int i = 1; i < 9; i++) smp(0, 1, seq9[i]);
        cmp("wrap.Rev0", int'(Rev), 0);

        // error saturation
        for (int k = 0; k < 17; k++) begin
            smp(0, 1, 4'b0101);
            lock_from_idle();
        end
        cmp("sat.ErrCnt", int'(ErrCnt), 15);

        // reset wins over an enabled legal sample
        smp(1, 1, 4'b1000);
        cmp("clr.Idx", int'(Idx), 0);
        cmp("clr.OneHot", int'(OneHot), 0);
        cmp("clr.Valid", int'(Valid), 0);
        cmp("clr.Locked", int'(Locked), 0);
        cmp("clr.ErrCnt", int'(ErrCnt), 0);
        cmp("clr.Rev", int'(Rev), 0);

        // tracking: non-successor legal restarts, stall holds, illegal drops to idle
        smp(0, 1, 4'b0000); smp(0, 1, 4'b1100); smp(0, 1, 4'b1110);
        smp(0, 1, 4'b1110);
        cmp("trk.StallNoLock", int'(Locked), 0);
        smp(0, 0, 4'b0000);
        smp(0, 1, 4'b1111);
        cmp("trk.Lock", int'(Locked), 1);
        smp(1, 0, 4'b0000);
        smp(0, 1, 4'b1000); smp(0, 1, 4'b0101);
        cmp("trk.IllNoErr", int'(SeqErr), 0);
        smp(0, 1, 4'b1100); smp(0, 1, 4'b1110); smp(0, 1, 4'b1111);
        cmp("trk.Relock", int'(Locked), 1);
        cmp("trk.ErrCnt", int'(ErrCnt), 0);

        // locked at 0001 with reset and a would-be wrap sample together
        smp(0, 1, 4'b0111); smp(0, 1, 4'b0011); smp(0, 1, 4'b0001);
        smp(1, 1, 4'b0000);
        cmp("clrwrap.Rev", int'(Rev), 0);
        cmp("clrwrap.Locked", int'(Locked), 0);
        smp(0, 0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/johnson_seq_monitor.md
JOHNSON_SEQ_MONITOR -- requirements
Module: johnson_seq_monitor

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Clr  input  1  reset, synchronous, active-high.
REQ-004 En  input  1  sample enable; Q is sampled only on edges where En=1.
REQ-005 Q  input  4  code from the upstream 4-bit Johnson counter; Q[3] is the MSB.
REQ-006 Idx  output  3  decoded state index of the last sample.
REQ-007 OneHot  output  8  OneHot[Idx]=1 when the last sample was legal.
REQ-008 Valid  output  1  last sample was a legal Johnson code.
REQ-009 Illegal  output  1  last sample was an illegal code.
REQ-010 SeqErr  output  1  one-cycle pulse on a sequence violation while locked.
REQ-011 Locked  output  1  monitor is in state LOCKED.
REQ-012 Rev  output  8  completed-revolution count.
REQ-013 ErrCnt  output  4  saturating count of SeqErr events.

Function
REQ-014 SHALL decode 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7; the other 8 codes are illegal.
REQ-015 SHALL define succ(c) = {~c[0], c[3:1]}, e.g. succ(0001)=0000.
REQ-016 All outputs SHALL be registered, with latency 1: an En=1 sample at edge N is visible after edge N.
REQ-017 On an illegal sample: Valid=0, Illegal=1, Idx=0, OneHot=0.
REQ-018 On a legal sample: Valid=1, Illegal=0, Idx and OneHot decoded per REQ-014.
REQ-019 SHALL keep a prev-code register and a 2-bit good counter, both loaded only on En=1.
REQ-020 SHALL implement states IDLE, TRACK and LOCKED; the state and prev code SHALL be internal.
REQ-021 IDLE: a legal sample goes to TRACK with good=0; an illegal sample stays in IDLE.
REQ-022 TRACK: sample==succ(prev) increments good; on reaching 2 the block goes to LOCKED.
REQ-023 TRACK: sample==prev changes neither state nor good.
REQ-024 TRACK: any other legal sample stays in TRACK with good=0.
REQ-025 TRACK: an illegal sample goes to IDLE.
REQ-026 LOCKED: sample==succ(prev) or sample==prev (stall) stays in LOCKED with no error.
REQ-027 LOCKED: any other sample SHALL pulse SeqErr=1 for one cycle and increment ErrCnt.
REQ-028 After REQ-027, the next state SHALL be TRACK (good=0) for a legal sample and IDLE for an illegal one.
REQ-029 ErrCnt SHALL saturate at 15.
REQ-030 Rev SHALL increment by 1 when, in LOCKED, prev=0001 and the sample is 0000; Rev wraps from 255 to 0.
REQ-031 En=0 SHALL hold every output except SeqErr, which returns to 0.
REQ-032 Locked SHALL equal (state==LOCKED) in the same cycle the state register updates.

Reset
REQ-033 Clr=1 at an edge SHALL force state=IDLE, prev=0000, good=0, Idx=0, OneHot=0, Valid=0, Illegal=0, SeqErr=0, Locked=0, Rev=0, ErrCnt=0.
REQ-034 Clr SHALL take priority over En and over any in-progress event, including mid-lock and a simultaneous wrap or error.
REQ-035 Clr=0 SHALL have no asynchronous effect.

Verification
REQ-036 Clr, then En=1 with samples 0000,1000,1100,1110,1111,0111,0011,0001,0000 -> Idx 0..7 then 0.
REQ-037 Same run as REQ-036 -> Locked=1 after the 3rd sample, and Rev=1, SeqErr=0 after the 9th.
REQ-038 Locked at 1100, sample 0101 -> Illegal=1, Valid=0, OneHot=0, SeqErr=1 for one cycle, ErrCnt=1, Locked=0.
REQ-039 Locked at 1100, sample 1111 -> SeqErr=1, Idx=4, Locked=0 (TRACK); 0111 then 0011 -> Locked=1 again.
REQ-040 Locked, repeated 1110 samples with En=1 and then En=0 for 5 cycles -> no SeqErr; Idx=3 held.
REQ-041 17 error events -> ErrCnt=15; then Clr=1 with En=1 and a legal Q -> every output is 0 one cycle later.
